// File: rtl/sw_engine_dispatch.sv
// sw_engine_dispatch: round-robin job dispatcher for Smith-Waterman lanes.
// Streams symbols to one engine per job, returns results in dispatch order.
module sw_engine_dispatch #(
  parameter int NUM_ENGINES    = 4,
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = 512
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_conf,
  input  logic [31:0]                           in_count,
  input  logic [DATA_IN_WIDTH-1:0]              in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [NUM_ENGINES-1:0]                eng_conf,
  output logic [31:0]                           eng_count,
  output logic [DATA_IN_WIDTH-1:0]              eng_data,
  output logic [NUM_ENGINES-1:0]                eng_valid,
  input  logic [NUM_ENGINES*DATA_OUT_WIDTH-1:0] eng_res_data,
  input  logic [NUM_ENGINES-1:0]                eng_res_valid,
  output logic [DATA_OUT_WIDTH-1:0]             out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic [31:0]                           job_cnt
);

  localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int CW = $clog2(NUM_ENGINES + 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_ENGINES-1:0]    r_busy;
  logic [NUM_ENGINES-1:0]    r_full;
  logic [DATA_OUT_WIDTH-1:0] r_hold [NUM_ENGINES];
  logic [IW-1:0]             r_ord  [NUM_ENGINES];
  logic [IW-1:0]             r_wp;
  logic [IW-1:0]             r_rp;
  logic [CW-1:0]             r_cnt;
  logic [IW-1:0]             r_last;
  logic [IW-1:0]             r_sel;
  logic [31:0]               r_rem;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic          w_conf_acc;
  logic          w_beat;
  logic          w_pop;
  logic [IW-1:0] w_head;

  function automatic logic [IW-1:0] f_rr(
    input logic [IW-1:0] b,
    input int            k
  );
    int s;
    s = int'(b) + k;
    if (s >= NUM_ENGINES) s = s - NUM_ENGINES;
    return IW'(s);
  endfunction

  function automatic logic [IW-1:0] f_inc(
    input logic [IW-1:0] p
  );
    return (p == IW'(NUM_ENGINES - 1)) ? '0 : p + IW'(1);
  endfunction

  // round-robin search: first free engine after the last dispatched one
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_ENGINES; i++) begin
      if (!w_found && !r_busy[f_rr(r_last, i)]) begin
        w_found = 1'b1;
        w_pick  = f_rr(r_last, i);
      end
    end
  end

  assign w_conf_acc = (r_state == S_IDLE) && in_conf && w_found;
  assign w_beat     = (r_state == S_STREAM) && in_valid;
  assign w_head     = r_ord[r_rp];
  assign out_valid  = (r_cnt != '0) && r_full[w_head];
  assign out_data   = out_valid ? r_hold[w_head] : '0;
  assign w_pop      = out_valid && out_ready;
  assign busy       = (|r_busy) || (r_state != S_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and in_ready
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = w_found;
        if (w_conf_acc && (in_count != 32'd0))
          w_next = S_STREAM;
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && (r_rem == 32'd1))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // job start: conf pulse, count, selected lane and remaining beats
  always_ff @(posedge clk) begin
    if (!reset) begin
      eng_conf  <= '0;
      eng_count <= '0;
      r_sel     <= '0;
      r_last    <= IW'(NUM_ENGINES - 1);
      r_rem     <= '0;
    end else begin
      eng_conf  <= '0;
      eng_count <= '0;
      if (w_conf_acc) begin
        eng_conf  <= NUM_ENGINES'(1) << w_pick;
        eng_count <= in_count;
        r_sel     <= w_pick;
        r_last    <= w_pick;
        r_rem     <= in_count;
      end else if (w_beat) begin
        r_rem <= r_rem - 32'd1;
      end
    end
  end

  // symbol broadcast with one-hot valid toward the streaming lane
  always_ff @(posedge clk) begin
    if (!reset) begin
      eng_valid <= '0;
      eng_data  <= '0;
    end else begin
      eng_valid <= '0;
      if (w_beat) begin
        eng_valid <= NUM_ENGINES'(1) << r_sel;
        eng_data  <= in_data;
      end
    end
  end

  // per-engine busy/full flags: set on dispatch/capture, cleared on drain
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= '0;
      r_full <= '0;
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (w_pop && (w_head == IW'(i))) begin
          r_busy[i] <= 1'b0;
          r_full[i] <= 1'b0;
        end
        if (w_conf_acc && (w_pick == IW'(i)))
          r_busy[i] <= 1'b1;
        if (eng_res_valid[i] && r_busy[i] && !r_full[i])
          r_full[i] <= 1'b1;
      end
    end
  end

  // result holding registers, gated by the same capture condition
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (eng_res_valid[i] && r_busy[i] && !r_full[i])
        r_hold[i] <= eng_res_data[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
    end
  end

  // dispatch-order FIFO of engine indices
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < NUM_ENGINES; i++)
        r_ord[i] <= '0;
    end else begin
      if (w_conf_acc) begin
        r_ord[r_wp] <= w_pick;
        r_wp        <= f_inc(r_wp);
      end
      if (w_pop)
        r_rp <= f_inc(r_rp);
      r_cnt <= r_cnt + CW'(w_conf_acc) - CW'(w_pop);
    end
  end

  // delivered-result counter
  always_ff @(posedge clk) begin
    if (!reset)     job_cnt <= '0;
    else if (w_pop) job_cnt <= job_cnt + 32'd1;
  end

endmodule

// File: tb/tb_sw_engine_dispatch.sv
// tb_sw_engine_dispatch: scoreboard bench for sw_engine_dispatch.
// Expected results queued at dispatch, compared as out_* drains.
module tb_sw_engine_dispatch;

  localparam int N  = 4;
  localparam int DI = 8;
  localparam int DO = 512;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_conf = 1'b0;
  logic [31:0]     in_count = '0;
  logic [DI-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    eng_conf;
  logic [31:0]     eng_count;
  logic [DI-1:0]   eng_data;
  logic [N-1:0]    eng_valid;
  logic [N*DO-1:0] eng_res_data = '0;
  logic [N-1:0]    eng_res_valid = '0;
  logic [DO-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;
  logic [31:0]     job_cnt;

  sw_engine_dispatch #(
    .NUM_ENGINES(N),
    .DATA_IN_WIDTH(DI),
    .DATA_OUT_WIDTH(DO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_conf(in_conf),
    .in_count(in_count),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .eng_conf(eng_conf),
    .eng_count(eng_count),
    .eng_data(eng_data),
    .eng_valid(eng_valid),
    .eng_res_data(eng_res_data),
    .eng_res_valid(eng_res_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [DO-1:0] exp_q [$];
  int            ord_q [$];
  bit            tb_busy [N];
  int            tb_last;
  logic [DO-1:0] tb_res [N];
  logic [DO-1:0] hold_v;

  task automatic chk(
    input string         tag,
    input logic [DO-1:0] got,
    input logic [DO-1:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare every accepted output beat in dispatch order
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
        tb_busy[ord_q.pop_front()] = 1'b0;
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    ord_q.delete();
    for (int i = 0; i < N; i++) tb_busy[i] = 1'b0;
    tb_last = N - 1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  // conf a job of cnt symbols, then stream nsend of them
  task automatic send_job(input int cnt, input int nsend);
    int e;
    logic [DO-1:0] r;
    logic [DI-1:0] s;
    e = -1;
    for (int i = 1; i <= N; i++) begin
      if (e < 0 && !tb_busy[(tb_last + i) % N]) e = (tb_last + i) % N;
    end
    if (e < 0) begin
      chk("model_no_free", 0, 1);
      return;
    end
    chk("in_ready_conf", in_ready, 1);
    in_conf  = 1'b1;
    in_count = cnt;
    @(posedge clk); #1;
    in_conf  = 1'b0;
    chk("eng_conf", eng_conf, DO'(1) << e);
    chk("eng_count", eng_count, DO'(cnt));
    tb_busy[e] = 1'b1;
    tb_last = e;
    for (int k = 0; k < DO / 32; k++) r[k*32 +: 32] = $urandom;
    tb_res[e] = r;
    exp_q.push_back(r);
    ord_q.push_back(e);
    for (int b = 0; b < nsend; b++) begin
      s = DI'($urandom);
      in_valid = 1'b1;
      in_data  = s;
      @(posedge clk); #1;
      chk("eng_valid", eng_valid, DO'(1) << e);
      chk("eng_data", eng_data, DO'(s));
    end
    in_valid = 1'b0;
  endtask

  task automatic return_res(input int e);
    eng_res_data = '0;
    eng_res_data[e*DO +: DO] = tb_res[e];
    eng_res_valid = N'(1) << e;
    @(posedge clk); #1;
    eng_res_valid = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", DO'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_eng_conf", eng_conf, 0);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_eng_count", eng_count, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_job_cnt", job_cnt, 0);
    @(posedge clk); #1;

    // single job on engine 0
    send_job(3, 3);
    return_res(0);
    wait_drain();
    chk("job_cnt_1", job_cnt, 1);

    // four jobs, results return out of order under backpressure
    for (int j = 0; j < N; j++) send_job(2, 2);
    chk("full_in_ready", in_ready, 0);
    in_conf  = 1'b1;
    in_count = 32'd5;
    @(posedge clk); #1;
    in_conf  = 1'b0;
    chk("full_no_conf", eng_conf, 0);
    out_ready = 1'b0;
    return_res(3);
    return_res(1);
    return_res(0);
    return_res(2);
    hold_v = exp_q[0];
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, hold_v);
      chk("stall_busy", busy, 1);
      chk("stall_job_cnt", job_cnt, 1);
      @(posedge clk); #1;
    end
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("freed_in_ready", in_ready, 1);
    send_job(1, 1);
    out_ready = 1'b1;
    return_res(ord_q[ord_q.size()-1]);
    wait_drain();
    chk("job_cnt_6", job_cnt, 6);

    // zero-length job stays idle
    send_job(0, 0);
    chk("zero_in_ready", in_ready, 1);
    chk("zero_busy", busy, 1);
    return_res(ord_q[0]);
    wait_drain();
    chk("job_cnt_7", job_cnt, 7);

    // reset with a pending result and a job mid-stream
    out_ready = 1'b0;
    send_job(0, 0);
    return_res(ord_q[0]);
    send_job(4, 2);
    do_reset();
    chk("mid_busy", busy, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_job_cnt", job_cnt, 0);
    chk("mid_eng_valid", eng_valid, 0);
    return_res(0);
    chk("late_res_ignored", out_valid, 0);
    out_ready = 1'b1;
    send_job(1, 1);
    return_res(0);
    wait_drain();
    chk("job_cnt_post_rst", job_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sw_engine_dispatch.md
SW_ENGINE_DISPATCH -- requirements
Module: sw_engine_dispatch

Interface
REQ-001 Parameter NUM_ENGINES, default 4, number of Smith-Waterman engine lanes, legal 1..8.
REQ-002 Parameter DATA_IN_WIDTH, default 8, symbol width per beat toward engines.
REQ-003 Parameter DATA_OUT_WIDTH, default 512, result width per engine.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_conf  input  1  one-cycle job-start pulse, qualified by in_ready.
REQ-007 in_count  input  32  symbol count of the job, sampled with in_conf.
REQ-008 in_data / in_valid / in_ready  input/input/output  DATA_IN_WIDTH/1/1  symbol stream from requestor.
REQ-009 eng_conf  output  NUM_ENGINES  one-hot job-start pulse per engine.
REQ-010 eng_count  output  32  count broadcast, meaningful only with eng_conf.
REQ-011 eng_data / eng_valid  output  DATA_IN_WIDTH/NUM_ENGINES  symbol broadcast, one-hot valid.
REQ-012 eng_res_data / eng_res_valid  input  NUM_ENGINES*DATA_OUT_WIDTH/NUM_ENGINES  per-engine result, one-cycle pulse.
REQ-013 out_data / out_valid / out_ready  output/output/input  DATA_OUT_WIDTH/1/1  in-order result stream.
REQ-014 busy  output  1  high while any job outstanding or FSM not IDLE.
REQ-015 job_cnt  output  32  count of results delivered on out_*, wraps at 2^32.

Function
REQ-016 FSM states IDLE, STREAM; each engine has a busy flag set at dispatch, cleared when its result is accepted on out_*.
REQ-017 IDLE: in_ready SHALL be high only if at least one engine is free; in_conf is accepted only when in_ready is high.
REQ-018 Engine selection: round-robin, first free engine at or after (last dispatched + 1) mod NUM_ENGINES; after reset the search starts at engine 0.
REQ-019 On accepted in_conf: register eng_conf one-hot and eng_count for exactly one cycle (1-cycle latency), push engine index into order FIFO (depth NUM_ENGINES), load remaining = in_count.
REQ-020 in_count == 0: FSM stays IDLE; otherwise moves to STREAM.
REQ-021 STREAM: in_ready high; each in_valid beat forwarded to selected engine with 1-cycle latency; remaining decrements; on last beat (remaining == 1) return to IDLE.
REQ-022 in_conf asserted in STREAM SHALL be ignored; in_valid in IDLE SHALL be dropped.
REQ-023 Each eng_res_valid captures eng_res_data into that engine's holding register, marks it full; pulse from a non-busy engine SHALL be ignored.
REQ-024 Output drains in dispatch order: head of order FIFO selects holding register; out_valid high while that register is full.
REQ-025 out_data and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-026 On out_valid && out_ready: pop order FIFO, clear holding full flag and engine busy flag, increment job_cnt; the freed engine is eligible for dispatch the next cycle.
REQ-027 Result capture and drain of different engines in the same cycle SHALL both take effect.
REQ-028 Out-of-order completions SHALL be held until older jobs drain; no result lost or reordered.

Reset
REQ-029 While reset is low at a clock edge: FSM to IDLE, all busy/full flags clear, order FIFO empty, round-robin pointer to engine NUM_ENGINES-1, job_cnt 0.
REQ-030 Reset values: in_ready 1 after release, eng_conf 0, eng_valid 0, out_valid 0, busy 0, out_data 0, eng_count 0, eng_data 0.
REQ-031 Reset asserted mid-STREAM or with results pending SHALL abandon all jobs; late eng_res_valid after reset is ignored per REQ-023.

Verification
REQ-032 Single job, NUM_ENGINES=4: conf count=3, 3 symbols -> eng_conf=4'b0001 one cycle later, 3 beats on eng_valid[0], result returned -> one out beat, job_cnt=1.
REQ-033 Four jobs back-to-back, results returned in order 3,1,0,2 -> out_data delivered in order engine 0,1,2,3; job_cnt=4.
REQ-034 All 4 engines busy -> in_ready=0; in_conf ignored; drain one result -> in_ready=1 next cycle, next dispatch goes to freed engine.
REQ-035 out_ready held low 10 cycles with out_valid high -> out_data constant, no pop, busy stays 1.
REQ-036 conf count=0 -> eng_conf pulse, FSM stays IDLE, in_ready remains 1 if engines free.
REQ-037 reset low during STREAM with 2 beats remaining -> next cycle busy=0, out_valid=0, in_ready=1, job_cnt=0; subsequent job goes to engine 0.
